npu_bus_master: RTL and testbench
=================================

NPU_BUS_MASTER -- requirements
Module: npu_bus_master

Interface
REQ-001 SHALL have parameter POLL_TIMEOUT, default 1024, meaning the maximum number of poll reads before a poll command errors.
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of the burst length field.
REQ-003 SHALL have one clock; reset SHALL be synchronous and active-low.
REQ-004 clk  in  1  sole clock; all logic on its rising edge.
REQ-005 rst_ni  in  1  synchronous active-low reset.
REQ-006 cmd_valid/cmd_ready  in/out  1/1  command handshake; the command is accepted when both are 1 on the same edge.
REQ-007 cmd_op  in  2  command opcode: 0=WRITE, 1=READ, 2=POLL, 3=reserved (accepted and completes as a no-op).
REQ-008 cmd_addr  in  16  start address driven on addra.
REQ-009 cmd_inc  in  4  address increment applied per word; 0 means fixed address.
REQ-010 cmd_len  in  CNT_W  word count for WRITE/READ; 0 is treated as 1.
REQ-011 cmd_mask  in  32  POLL completion mask.
REQ-012 wr_data/wr_valid/wr_ready  in/in/out  32/1/1  write-source stream.
REQ-013 rd_data/rd_valid/rd_ready  out/out/in  32/1/1  read-sink stream.
REQ-014 done  out  1  one-cycle pulse when a command completes.
REQ-015 err  out  1  one-cycle pulse, coincident with done, when a POLL times out.
REQ-016 ena/wea/addra/dina  out  1/1/16/32  NPU host bus request.
REQ-017 douta  in  32  NPU read data, valid on the first edge after a read request.

Function
REQ-018 The FSM SHALL have the states IDLE, WR, RD_REQ, RD_WAIT, RD_HOLD, PL_REQ, PL_WAIT, FIN.
REQ-019 cmd_ready SHALL be 1 only in IDLE; on acceptance the block SHALL latch op, addr, inc, len and mask.
REQ-020 In WR, on an edge where wr_valid=1: wr_ready=1, ena=wea=1, dina=wr_data, addra=current address.
  - After each such edge: address += cmd_inc (mod 2^16), remaining count decrements.
  - After the last word the FSM SHALL go to FIN.
REQ-021 In WR with wr_valid=0, ena SHALL be 0 (bubble); the address SHALL NOT advance.
REQ-022 In RD_REQ the block SHALL drive ena=1, wea=0 for exactly one cycle, then go to RD_WAIT.
REQ-023 In RD_WAIT the block SHALL capture douta into rd_data, assert rd_valid, and go to RD_HOLD.
REQ-024 In RD_HOLD, rd_data and rd_valid SHALL hold until rd_ready=1; then address += inc and count decrements.
  - Next state is RD_REQ, or FIN after the last word.
  - Peak rate is one word per 3 cycles.
REQ-025 rd_valid=1 with rd_ready=0 SHALL NOT drop, change, or repeat data.
REQ-026 PL_REQ/PL_WAIT SHALL read the fixed cmd_addr.
  - Completion when (douta & cmd_mask) != 0.
  - Otherwise return to PL_REQ.
  - mask 0 SHALL never complete.
REQ-027 In FIN the block SHALL pulse done for one cycle, then return to IDLE; back-to-back commands SHALL therefore be separated by at least one idle cycle.
REQ-028 Outside WR/RD_REQ/PL_REQ, ena and wea SHALL be 0; addra and dina SHALL hold their last values.
REQ-029 Address wrap from 0xFFFF SHALL wrap to low addresses without error.

Reset
REQ-030 When rst_ni=0 at an edge, the block SHALL set state=IDLE, ena=wea=0, addra=0, dina=0, rd_data=0, rd_valid=0, done=0, err=0, poll counter=0.
REQ-031 When rst_ni=0 at an edge, cmd_ready SHALL read 0 during reset and 1 on the first cycle after release.
REQ-032 Reset asserted mid-burst or mid-poll SHALL abort the command with no done pulse; ena SHALL be 0 from the next edge.

Configuration
REQ-033 With macro NPU_BUS_MASTER_TIMEOUT_EN defined, each completed poll read SHALL increment a counter.
  - When the counter reaches POLL_TIMEOUT without a match, the FSM SHALL go to FIN and pulse done and err together.
REQ-034 Without NPU_BUS_MASTER_TIMEOUT_EN, POLL SHALL wait indefinitely, err SHALL be tied 0, and no counter SHALL exist.

Structure
REQ-035 Shared package npu_pkg SHALL hold:
  - opcode enum: OP_WRITE, OP_READ, OP_POLL.
  - NPU address-map constants: SEL_IMG=3'b001, SEL_WCONV=3'b010, SEL_FC1W=3'b011, SEL_FC2W=3'b100, SEL_CTRL=3'b101, SEL_STAT=3'b111.
  - status offsets: DONE=0, RESULT=4, PACK_VALID=8, PACK_DATA=12, FC1_VALID=16, FCN_DONE=20.
  - control bit indices: TRIGGER=0, FC1_NEXT=1, SAVE_DONE=2, NEXT_LAYER=3, START=4.
REQ-036 The block SHALL be a single module with no sub-module; the FSM enum SHALL be local.

Verification
REQ-037 WRITE addr 0x1000, inc 1, len 3, words A,B,C always valid -> ena=wea=1 for 3 consecutive cycles at addra 0x1000/0x1001/0x1002 with dina A/B/C; done 1 cycle later.
REQ-038 WRITE len 2 with wr_valid low for 2 cycles between words -> exactly 2 bus writes, addresses 0x2000 then 0x2001, no address skip.
REQ-039 READ addr 0x7000, inc 4, len 3, model douta=addr, rd_ready low 5 cycles on the 2nd word -> rd_data sequence 0x7000, 0x7004, 0x7008, 2nd word held stable, done after the 3rd.
REQ-040 POLL addr 0x7008, mask 1, douta bit0 rising after 10 reads -> exactly 11 read requests, done=1, err=0.
REQ-041 With NPU_BUS_MASTER_TIMEOUT_EN and POLL_TIMEOUT=4, douta=0 -> 4 reads, then done and err pulse together; without the macro -> still polling after 100 reads, err=0.
REQ-042 rst_ni low during a READ at word 2 -> next edge ena=0, rd_valid=0; no done pulse; cmd_ready=1 after release.

Source files
------------

// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared NPU opcodes, address map, status offsets and control bits
package npu_pkg;

    // Host command opcodes; 2'd3 is reserved and completes as a no-op
    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_POLL  = 2'd2
    } op_e;

    // NPU address-map region selects
    localparam logic [2:0] SEL_IMG   = 3'b001;
    localparam logic [2:0] SEL_WCONV = 3'b010;
    localparam logic [2:0] SEL_FC1W  = 3'b011;
    localparam logic [2:0] SEL_FC2W  = 3'b100;
    localparam logic [2:0] SEL_CTRL  = 3'b101;
    localparam logic [2:0] SEL_STAT  = 3'b111;

    // Status register byte offsets
    localparam logic [7:0] DONE       = 8'd0;
    localparam logic [7:0] RESULT     = 8'd4;
    localparam logic [7:0] PACK_VALID = 8'd8;
    localparam logic [7:0] PACK_DATA  = 8'd12;
    localparam logic [7:0] FC1_VALID  = 8'd16;
    localparam logic [7:0] FCN_DONE   = 8'd20;

    // Control register bit indices
    localparam int unsigned TRIGGER    = 0;
    localparam int unsigned FC1_NEXT   = 1;
    localparam int unsigned SAVE_DONE  = 2;
    localparam int unsigned NEXT_LAYER = 3;
    localparam int unsigned START      = 4;

endpackage

// File: rtl/npu_bus_master_if.sv
// rtl/npu_bus_master_if.sv - command, stream and NPU host-bus signals of npu_bus_master
interface npu_bus_master_if #(
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [15:0]      cmd_addr;
    logic [3:0]       cmd_inc;
    logic [CNT_W-1:0] cmd_len;
    logic [31:0]      cmd_mask;

    logic [31:0]      wr_data;
    logic             wr_valid;
    logic             wr_ready;

    logic [31:0]      rd_data;
    logic             rd_valid;
    logic             rd_ready;

    logic             done;
    logic             err;

    logic             ena;
    logic             wea;
    logic [15:0]      addra;
    logic [31:0]      dina;
    logic [31:0]      douta;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_inc, cmd_len, cmd_mask,
        output cmd_ready,
        input  wr_data, wr_valid,
        output wr_ready,
        output rd_data, rd_valid,
        input  rd_ready,
        output done, err,
        output ena, wea, addra, dina,
        input  douta
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_inc, cmd_len, cmd_mask,
        input  cmd_ready,
        output wr_data, wr_valid,
        input  wr_ready,
        input  rd_data, rd_valid,
        output rd_ready,
        input  done, err,
        input  ena, wea, addra, dina,
        output douta
    );

endinterface

// File: rtl/npu_bus_master.sv
// rtl/npu_bus_master.sv - command-driven WRITE/READ/POLL master for the NPU host bus (optional poll timeout: NPU_BUS_MASTER_TIMEOUT_EN)
module npu_bus_master
    import npu_pkg::*;
#(
    parameter int POLL_TIMEOUT = 1024,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_ni,
    npu_bus_master_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_RD_REQ, S_RD_WAIT, S_RD_HOLD, S_PL_REQ, S_PL_WAIT, S_FIN
    } state_e;

    state_e           state_q, state_d;
    logic [15:0]      addr_q, addr_d;       // working word pointer
    logic [15:0]      addra_q, addra_d;     // last address put on the bus
    logic [3:0]       inc_q, inc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;         // words still to transfer
    logic [31:0]      mask_q, mask_d;
    logic [31:0]      dina_q, dina_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    logic             wr_fire;
    logic             bus_req;
    logic [15:0]      addr_next;

`ifdef NPU_BUS_MASTER_TIMEOUT_EN
    localparam int PCNT_W = $clog2(POLL_TIMEOUT + 1);
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic [PCNT_W-1:0] pcnt_inc;
    logic              tmo_q, tmo_d;
    assign pcnt_inc = pcnt_q + 1'b1;
`endif

    // A write word moves on the same edge it is offered; reads and polls request for one state
    assign wr_fire   = (state_q == S_WR) && bus.wr_valid;
    assign bus_req   = wr_fire || (state_q == S_RD_REQ) || (state_q == S_PL_REQ);
    assign addr_next = addr_q + {12'd0, inc_q};

    assign bus.cmd_ready = rst_ni && (state_q == S_IDLE);
    assign bus.wr_ready  = (state_q == S_WR);
    assign bus.ena       = bus_req;
    assign bus.wea       = wr_fire;
    assign bus.addra     = bus_req ? addr_q : addra_q;
    assign bus.dina      = wr_fire ? bus.wr_data : dina_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.done      = (state_q == S_FIN);
`ifdef NPU_BUS_MASTER_TIMEOUT_EN
    assign bus.err       = (state_q == S_FIN) && tmo_q;
`else
    assign bus.err       = 1'b0;
`endif

    // Next-state and datapath computation for the command FSM
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        addra_d    = addra_q;
        inc_d      = inc_q;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        dina_d     = dina_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
`ifdef NPU_BUS_MASTER_TIMEOUT_EN
        pcnt_d     = pcnt_q;
        tmo_d      = tmo_q;
`endif
        if (bus_req) addra_d = addr_q;
        if (wr_fire) dina_d  = bus.wr_data;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d = bus.cmd_addr;
                    inc_d  = bus.cmd_inc;
                    mask_d = bus.cmd_mask;
                    cnt_d  = (bus.cmd_len == '0) ? CNT_W'(1) : bus.cmd_len;
`ifdef NPU_BUS_MASTER_TIMEOUT_EN
                    pcnt_d = '0;
                    tmo_d  = 1'b0;
`endif
                    case (bus.cmd_op)
                        OP_WRITE: state_d = S_WR;
                        OP_READ:  state_d = S_RD_REQ;
                        OP_POLL:  state_d = S_PL_REQ;
                        default:  state_d = S_FIN;
                    endcase
                end
            end
            S_WR: begin
                if (bus.wr_valid) begin
                    addr_d = addr_next;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_d = S_FIN;
                end
            end
            S_RD_REQ: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                rd_data_d  = bus.douta;
                rd_valid_d = 1'b1;
                state_d    = S_RD_HOLD;
            end
            S_RD_HOLD: begin
                if (bus.rd_ready) begin
                    rd_valid_d = 1'b0;
                    addr_d     = addr_next;
                    cnt_d      = cnt_q - 1'b1;
                    state_d    = (cnt_q == CNT_W'(1)) ? S_FIN : S_RD_REQ;
                end
            end
            S_PL_REQ: state_d = S_PL_WAIT;
            S_PL_WAIT: begin
`ifdef NPU_BUS_MASTER_TIMEOUT_EN
                pcnt_d = pcnt_inc;
`endif
                if ((bus.douta & mask_q) != 32'd0) begin
                    state_d = S_FIN;
                end else begin
`ifdef NPU_BUS_MASTER_TIMEOUT_EN
                    if (pcnt_inc == PCNT_W'(POLL_TIMEOUT)) begin
                        state_d = S_FIN;
                        tmo_d   = 1'b1;
                    end else begin
                        state_d = S_PL_REQ;
                    end
`else
                    state_d = S_PL_REQ;
`endif
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            addra_q    <= '0;
            inc_q      <= '0;
            cnt_q      <= '0;
            mask_q     <= '0;
            dina_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
`ifdef NPU_BUS_MASTER_TIMEOUT_EN
            pcnt_q     <= '0;
            tmo_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            addra_q    <= addra_d;
            inc_q      <= inc_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            dina_q     <= dina_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
`ifdef NPU_BUS_MASTER_TIMEOUT_EN
            pcnt_q     <= pcnt_d;
            tmo_q      <= tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_npu_bus_master.sv
// tb/tb_npu_bus_master.sv - directed self-checking bench for npu_bus_master
module tb_npu_bus_master;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    npu_bus_master_if #(.CNT_W(8)) bus ();

    npu_bus_master #(.POLL_TIMEOUT(4), .CNT_W(8)) u_dut (
        .clk    (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mode  = 0;
    int rd_req_n, done_n, err_n, done_cyc, err_cyc;
    logic [15:0] last_rd_addr;
    logic [15:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    logic [31:0] rdat_q[$];
    int          rc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memory model: data for a read request appears after the request edge
    always @(posedge clk) begin
        if (bus.ena && !bus.wea) begin
            case (mode)
                0:       bus.douta <= {16'h0, bus.addra};
                1:       bus.douta <= (rd_req_n >= 11) ? 32'h1 : 32'h0;
                2:       bus.douta <= 32'h0;
                default: bus.douta <= 32'hFFFF_FFFF;
            endcase
        end
    end

    // Bus and stream monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.ena && bus.wea) begin
            wa_q.push_back(bus.addra);
            wd_q.push_back(bus.dina);
            wc_q.push_back(cyc);
        end
        if (bus.ena && !bus.wea) begin
            rd_req_n     = rd_req_n + 1;
            last_rd_addr = bus.addra;
        end
        if (bus.done) begin
            done_n   = done_n + 1;
            done_cyc = cyc;
        end
        if (bus.err) begin
            err_n   = err_n + 1;
            err_cyc = cyc;
        end
        if (bus.rd_valid && bus.rd_ready) begin
            rdat_q.push_back(bus.rd_data);
            rc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wa(int i);
        if (i < wa_q.size()) return {16'h0, wa_q[i]};
        return 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] wd(int i);
        if (i < wd_q.size()) return wd_q[i];
        return 32'hBAD0_BAD0;
    endfunction
    function automatic int wc(int i);
        if (i < wc_q.size()) return wc_q[i];
        return -100;
    endfunction
    function automatic logic [31:0] rd(int i);
        if (i < rdat_q.size()) return rdat_q[i];
        return 32'hFFFF_FFFF;
    endfunction
    function automatic int rc(int i);
        if (i < rc_q.size()) return rc_q[i];
        return -100;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        rd_req_n = 0; done_n = 0; err_n = 0; done_cyc = -1; err_cyc = -2;
        wa_q.delete(); wd_q.delete(); wc_q.delete(); rdat_q.delete(); rc_q.delete();
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [15:0] addr, input logic [3:0] inc,
                            input logic [7:0] len, input logic [31:0] mask);
        int n;
        tick();
        bus.cmd_op = op; bus.cmd_addr = addr; bus.cmd_inc = inc;
        bus.cmd_len = len; bus.cmd_mask = mask; bus.cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        tick();
        bus.cmd_valid = 1'b0;
        check("cmd_accepted", (n < 50) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int max);
        int n;
        n = 0;
        while (done_n == 0 && n < max) begin
            tick();
            n++;
        end
    endtask

    logic [31:0] wdat[3] = '{32'hA5A5_0001, 32'h5A5A_0002, 32'hDEAD_BEEF};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, stall, unstable;
        bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_addr = 0; bus.cmd_inc = 0;
        bus.cmd_len = 0; bus.cmd_mask = 0; bus.wr_data = 0; bus.wr_valid = 0;
        bus.rd_ready = 0; bus.douta = 0;
        clear_logs();

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_ena", bus.ena, 0);
        check("rst_wea", bus.wea, 0);
        check("rst_addra", bus.addra, 0);
        check("rst_dina", bus.dina, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        tick();
        rst_ni = 1'b1;
        @(negedge clk);
        check("rel_cmd_ready", bus.cmd_ready, 1);

        // WRITE 0x1000 inc 1 len 3, data always valid
        clear_logs();
        send_cmd(2'd0, 16'h1000, 4'd1, 8'd3, 32'd0);
        for (int i = 0; i < 3; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = wdat[i];
            tick();
        end
        bus.wr_valid = 1'b0;
        wait_done(10);
        check("w1_count", wa_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check("w1_addr", wa(i), 32'h1000 + i);
            check("w1_data", wd(i), wdat[i]);
        end
        check("w1_consecutive", wc(2) - wc(0), 2);
        check("w1_done_cycle", done_cyc, wc(2) + 1);
        check("w1_done_count", done_n, 1);

        // WRITE 0x2000 len 2 with two bubble cycles between words
        clear_logs();
        send_cmd(2'd0, 16'h2000, 4'd1, 8'd2, 32'd0);
        bus.wr_valid = 1'b1; bus.wr_data = 32'h1111_2222;
        tick();
        bus.wr_valid = 1'b0;
        tick();
        tick();
        bus.wr_valid = 1'b1; bus.wr_data = 32'h3333_4444;
        tick();
        bus.wr_valid = 1'b0;
        wait_done(10);
        check("w2_count", wa_q.size(), 2);
        check("w2_addr0", wa(0), 32'h2000);
        check("w2_addr1", wa(1), 32'h2001);
        check("w2_data1", wd(1), 32'h3333_4444);
        check("w2_gap", wc(1) - wc(0), 3);
        check("w2_done", done_n, 1);
        tick();
        @(negedge clk);
        check("w2_hold_ena", bus.ena, 0);
        check("w2_hold_addra", bus.addra, 32'h2001);
        check("w2_hold_dina", bus.dina, 32'h3333_4444);

        // READ 0x7000 inc 4 len 3, sink stalls 5 cycles on the second word
        mode = 0;
        clear_logs();
        bus.rd_ready = 1'b1;
        send_cmd(2'd1, 16'h7000, 4'd4, 8'd3, 32'd0);
        stall = 0; unstable = 0; n = 0;
        while (done_n == 0 && n < 100) begin
            @(negedge clk);
            if (bus.rd_valid && !bus.rd_ready) begin
                stall++;
                if (bus.rd_data !== 32'h7004) unstable++;
            end
            tick();
            bus.rd_ready = !(rdat_q.size() == 1 && stall < 5);
            n++;
        end
        bus.rd_ready = 1'b1;
        check("r_count", rdat_q.size(), 3);
        check("r_data0", rd(0), 32'h7000);
        check("r_data1", rd(1), 32'h7004);
        check("r_data2", rd(2), 32'h7008);
        check("r_stall", stall, 5);
        check("r_stable", unstable, 0);
        check("r_requests", rd_req_n, 3);
        check("r_done", done_n, 1);
        check("r_done_cycle", done_cyc, rc(2) + 1);

        // POLL 0x7008 mask 1, bit0 rises on the 11th read
        mode = 1;
        clear_logs();
        send_cmd(2'd2, 16'h7008, 4'd0, 8'd1, 32'd1);
        wait_done(100);
        check("p_requests", rd_req_n, 11);
        check("p_done", done_n, 1);
        check("p_err", err_n, 0);
        check("p_addr", last_rd_addr, 32'h7008);

`ifdef NPU_BUS_MASTER_TIMEOUT_EN
        // POLL times out after POLL_TIMEOUT=4 reads
        mode = 2;
        clear_logs();
        send_cmd(2'd2, 16'h7008, 4'd0, 8'd1, 32'd1);
        wait_done(50);
        check("t_requests", rd_req_n, 4);
        check("t_done", done_n, 1);
        check("t_err", err_n, 1);
        check("t_err_with_done", err_cyc, done_cyc);
`else
        // POLL without timeout keeps polling; reset aborts it
        mode = 2;
        clear_logs();
        send_cmd(2'd2, 16'h7008, 4'd0, 8'd1, 32'd1);
        n = 0;
        while (rd_req_n < 101 && n < 400) begin
            tick();
            n++;
        end
        check("t_still_polling", (rd_req_n > 100) ? 32'd1 : 32'd0, 32'd1);
        check("t_no_done", done_n, 0);
        check("t_no_err", err_n, 0);
        rst_ni = 1'b0;
        tick();
        @(negedge clk);
        check("t_abort_ena", bus.ena, 0);
        tick();
        rst_ni = 1'b1;

        // Mask 0 never completes, even with all data bits set
        mode = 3;
        clear_logs();
        send_cmd(2'd2, 16'h0100, 4'd0, 8'd1, 32'd0);
        n = 0;
        while (rd_req_n < 20 && n < 100) begin
            tick();
            n++;
        end
        check("m0_polling", (rd_req_n >= 20) ? 32'd1 : 32'd0, 32'd1);
        check("m0_no_done", done_n, 0);
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
`endif

        // Reset during the second word of a READ
        mode = 0;
        clear_logs();
        bus.rd_ready = 1'b1;
        send_cmd(2'd1, 16'h3000, 4'd1, 8'd4, 32'd0);
        n = 0;
        while (rdat_q.size() < 1 && n < 20) begin
            tick();
            n++;
        end
        bus.rd_ready = 1'b0;
        n = 0;
        while (!bus.rd_valid && n < 20) begin
            tick();
            n++;
        end
        check("ra_word2_valid", bus.rd_valid, 1);
        check("ra_word2_data", bus.rd_data, 32'h3001);
        rst_ni = 1'b0;
        tick();
        @(negedge clk);
        check("ra_ena", bus.ena, 0);
        check("ra_rd_valid", bus.rd_valid, 0);
        check("ra_cmd_ready_in_rst", bus.cmd_ready, 0);
        tick();
        rst_ni = 1'b1;
        bus.rd_ready = 1'b1;
        @(negedge clk);
        check("ra_cmd_ready", bus.cmd_ready, 1);
        check("ra_no_done", done_n, 0);

        // Reserved opcode completes with no bus activity
        clear_logs();
        send_cmd(2'd3, 16'h1234, 4'd0, 8'd0, 32'd0);
        wait_done(10);
        check("nop_done", done_n, 1);
        check("nop_writes", wa_q.size(), 0);
        check("nop_reads", rd_req_n, 0);

        // WRITE with len 0 moves exactly one word
        clear_logs();
        send_cmd(2'd0, 16'h0040, 4'd1, 8'd0, 32'd0);
        bus.wr_valid = 1'b1; bus.wr_data = 32'hCAFE_0040;
        tick();
        bus.wr_valid = 1'b0;
        wait_done(10);
        check("len0_count", wa_q.size(), 1);
        check("len0_addr", wa(0), 32'h0040);
        check("len0_done", done_n, 1);

        // Address wraps past 0xFFFF
        clear_logs();
        send_cmd(2'd0, 16'hFFFF, 4'd2, 8'd2, 32'd0);
        bus.wr_valid = 1'b1; bus.wr_data = 32'h0000_00F0;
        tick();
        bus.wr_data = 32'h0000_00F1;
        tick();
        bus.wr_valid = 1'b0;
        wait_done(10);
        check("wrap_addr0", wa(0), 32'hFFFF);
        check("wrap_addr1", wa(1), 32'h0001);
        check("wrap_done", done_n, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
